div_ctrl: RTL

- Multi-cycle integer divide unit and its sequencer, sitting beside the execute-stage ALU.
- Serves DIV.W, MOD.W, DIV.WU and MOD.WU.
- Accepts one operation from the execute stage and runs a 32-iteration radix-2 restoring divide.
- Drives the stall request that the execute stage ORs into its pause output, and returns the quotient or remainder with a one-cycle ready pulse.
- Flushable by a pipeline cancel.

---
 rtl/div_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU with stall request and flush.
// Latency: 33 cycles from accept to ready_o (1 cycle for divide-by-zero); DIV_EARLY_OUT_EN also makes |a|<|b| finish in 1 cycle.
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             op_mod_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             cancel_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ready_o,
    output logic             pause_o,
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_result;
    logic             r_qsign;
    logic             r_rsign;
    logic             r_mod;

    logic             w_accept;
    logic             w_div_zero;
    logic             w_early;
    logic             w_fast;
    logic             w_last;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dsr_mag;
    logic [WIDTH-1:0] w_fast_res;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_quo_fix;

    assign w_accept   = start_i & ~cancel_i;
    assign w_dvd_mag  = (signed_i & dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    assign w_dsr_mag  = (signed_i & divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;
    assign w_div_zero = (divisor_i == '0);
`ifdef DIV_EARLY_OUT_EN
    assign w_early    = ~w_div_zero & (w_dvd_mag < w_dsr_mag);
`else
    assign w_early    = 1'b0;
`endif
    assign w_fast     = w_div_zero | w_early;
    // Both fast paths return the raw dividend as remainder; only the quotient differs.
    assign w_fast_res = op_mod_i ? dividend_i : (w_div_zero ? '1 : '0);

    // 33-bit partial remainder so divisors with the MSB set cannot lose the shifted-out bit.
    assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_dsr};
    assign w_borrow   = w_diff[WIDTH];
    assign w_rem_nxt  = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quo_nxt  = {r_quo[WIDTH-2:0], ~w_borrow};
    assign w_quo_fix  = r_qsign ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_fix  = r_rsign ? -w_rem_nxt : w_rem_nxt;
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_fast ? S_DONE : S_BUSY;
            S_BUSY:  if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (cancel_i) w_next = S_IDLE;
    end

    // Result is registered on entry to DONE so it is stable for the whole ready cycle and after.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dsr    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_result <= '0;
            r_qsign  <= 1'b0;
            r_rsign  <= 1'b0;
            r_mod    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dvd   <= w_dvd_mag;
                        r_dsr   <= w_dsr_mag;
                        r_quo   <= '0;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_mod   <= op_mod_i;
                        r_qsign <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                        r_rsign <= signed_i & dividend_i[WIDTH-1];
                        if (w_fast) r_result <= w_fast_res;
                    end
                end
                S_BUSY: begin
                    if (!cancel_i) begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) r_result <= r_mod ? w_rem_fix : w_quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = (r_state == S_DONE);
    assign busy_o   = (r_state != S_IDLE);
    assign pause_o  = start_i & ~ready_o & ~cancel_i;

endmodule
